mips_muldiv: RTL and testbench
==============================

MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width; SHALL be even and >= 8.
REQ-002 Parameter STEPS, default 1: iteration bits per cycle; SHALL divide WIDTH.
REQ-003 clock  in  1  rising-edge clock, single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begin operation; accepted only while busy=0.
REQ-006 op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 src_a / src_b  in  WIDTH each  multiplicand/dividend, multiplier/divisor; sampled at the accepting edge.
REQ-008 flush  in  1  abort the in-flight operation (branch squash).
REQ-009 hi_we / lo_we / wdata  in  1/1/WIDTH  MTHI/MTLO write port.
REQ-010 busy  out  1  operation in flight; the pipeline stalls on it.
REQ-011 done  out  1  one-cycle pulse; HI/LO results valid.
REQ-012 hi / lo  out  WIDTH each  architectural HI/LO registers.
REQ-013 div_by_zero  out  1  qualified by done.

Function
REQ-014 States: IDLE, CALC, FIX; encoding in the shared package.
REQ-015 IDLE: start=1 -> CALC; operands latched (absolute values when op is signed); count loaded with N=WIDTH/STEPS; busy=1 from the next cycle.
REQ-016 CALC: STEPS shift-add (mul) or restoring shift-subtract (div) steps per cycle; count decrements; at count=1 -> FIX.
REQ-017 FIX: sign correction applied; HI/LO written; -> IDLE; done=1 and busy=0 in the cycle after FIX.
REQ-018 Latency: done asserts exactly N+2 cycles after the accepting edge (34 for WIDTH=32, STEPS=1).
REQ-019 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, two's-complement for MULT.
REQ-020 DIV/DIVU: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
REQ-021 Divisor 0: lo = all ones, hi = src_a, div_by_zero=1 with done; latency unchanged.
REQ-022 DIV of the most-negative value by -1: lo = most-negative value, hi = 0, div_by_zero=0.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 flush while busy: return to IDLE next edge; hi/lo unchanged; no done pulse. flush while idle: no effect. flush with start: start is dropped.
REQ-025 hi_we/lo_we while idle: register written at that edge. While busy: ignored. Same cycle as an accepted start: the write is dropped.
REQ-026 hi/lo change only on a FIX exit, an MTHI/MTLO write, or reset.

Reset
REQ-027 reset=1 at an edge: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, count=0.
REQ-028 reset mid-operation SHALL abort the operation without a done pulse; reset outranks every other input.

Configuration
REQ-029 Macro MIPS_MULDIV_DIV_EN defined: all four ops are implemented.
REQ-030 MIPS_MULDIV_DIV_EN undefined: divider logic is absent; start with op[1]=1 is ignored (busy stays 0, no done); div_by_zero is tied 0.

Structure
REQ-031 Package mips_pkg SHALL hold the op encoding enum muldiv_op_t and the state enum muldiv_state_t.
REQ-032 Sub-module mips_muldiv_step SHALL be a combinational single-bit mul/div step, instantiated STEPS times in a chain.
REQ-033 Latency and counter width SHALL derive from WIDTH and STEPS only, with no hard-coded 32.

Verification
REQ-034 MULT, WIDTH=32: src_a=-3, src_b=7 -> after 34 cycles done=1, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-035 DIV: src_a=-7, src_b=2 -> lo=-3, hi=-1. DIVU: 7/0 -> lo=32'hFFFFFFFF, hi=7, div_by_zero=1.
REQ-036 DIV 32'h80000000 by -1 -> lo=32'h80000000, hi=0. DIVU 32'hFFFFFFFF by 1 -> lo=32'hFFFFFFFF, hi=0.
REQ-037 start at cycle t, second start at t+5, flush at t+10 -> busy drops at t+11, no done pulse, prior hi/lo retained, second start never executed.
REQ-038 MTLO 5 while idle -> lo=5 next cycle. MTHI while busy -> hi unchanged. reset at t+3 of a MULT -> all outputs 0, no done pulse.
REQ-039 WIDTH=16, STEPS=4: MULTU 16'hFFFF*16'hFFFF -> done after 6 cycles, hi=16'hFFFE, lo=16'h0001. With the macro undefined, DIVU start -> busy stays 0.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg -- shared types for the MIPS HI/LO multiply/divide unit.
//   muldiv_op_t    : operation encoding seen on the op port
//   muldiv_state_t : sequencer states (IDLE -> CALC -> FIX -> IDLE)
//   op_is_signed / op_is_div : decode helpers used by the top level
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } muldiv_state_t;

    function automatic logic op_is_signed(input muldiv_op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t o);
        return (o == OP_DIVU) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// ---------------------------------------------------------------------------
// mips_muldiv_step -- one combinational iteration of the unsigned datapath.
//   Multiply: shift-add. If lo_in[0] the operand (multiplicand) is added to
//             hi_in, then {carry, hi, lo} shifts right by one.
//   Divide  : restoring shift-subtract. {hi, lo} shifts left, the operand
//             (divisor) is trial-subtracted from the partial remainder and
//             the quotient bit enters at lo[0]. Only present when
//             MIPS_MULDIV_DIV_EN is defined.
// Ports: is_div, hi_in, lo_in, operand -> hi_out, lo_out (all WIDTH wide).
// ---------------------------------------------------------------------------
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] sum_s;

`ifdef MIPS_MULDIV_DIV_EN
    logic [WIDTH:0] rem_s;
    logic [WIDTH:0] diff_s;

    // One multiply or divide iteration selected by is_div.
    always_comb begin
        sum_s  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        rem_s  = {hi_in, lo_in[WIDTH-1]};
        diff_s = rem_s - {1'b0, operand};
        if (is_div) begin
            // The partial remainder is always below the divisor, so the
            // shifted value is below 2*divisor and bit WIDTH of the
            // difference is a clean borrow flag.
            if (!diff_s[WIDTH]) begin
                hi_out = diff_s[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = rem_s[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_out = sum_s[WIDTH:1];
            lo_out = {sum_s[0], lo_in[WIDTH-1:1]};
        end
    end
`else
    logic unused_s;
    assign unused_s = is_div;

    // Multiply-only iteration; the divider is not built.
    always_comb begin
        sum_s  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        hi_out = sum_s[WIDTH:1];
        lo_out = {sum_s[0], lo_in[WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/mips_muldiv.sv
// ---------------------------------------------------------------------------
// mips_muldiv -- iterative MIPS multiply/divide unit with HI/LO registers.
// Inputs : clock, reset (sync, active high), start, op[1:0], src_a, src_b,
//          flush, hi_we, lo_we, wdata.
// Outputs: busy, done (one-cycle pulse), hi, lo, div_by_zero (with done).
// Operation runs on operand magnitudes for WIDTH/STEPS CALC cycles, then a
// FIX cycle applies sign correction and writes HI/LO.
// Optional feature: define MIPS_MULDIV_DIV_EN to build DIV/DIVU; otherwise
// divide starts are ignored and div_by_zero is tied low.
// ---------------------------------------------------------------------------
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int N  = WIDTH / STEPS;
    localparam int CW = $clog2(N + 1);

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, mcand_q, mcand_d;
    logic             is_div_q, is_div_d, neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
`ifdef MIPS_MULDIV_DIV_EN
    logic             neg_rem_q, neg_rem_d, dbz_q, dbz_d, dbz_out_q, dbz_out_d;
`endif

    muldiv_op_t         op_s;
    logic               signed_s, div_op_s, op_ok_s, accept_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s, fix_hi_s, fix_lo_s, step_hi_s, step_lo_s;
    logic [2*WIDTH-1:0] prod_s;

    // Operand decode: magnitudes for signed ops and start acceptance.
    always_comb begin
        op_s     = muldiv_op_t'(op);
        signed_s = op_is_signed(op_s);
        div_op_s = op_is_div(op_s);
        a_neg_s  = signed_s & src_a[WIDTH-1];
        b_neg_s  = signed_s & src_b[WIDTH-1];
        abs_a_s  = a_neg_s ? -src_a : src_a;
        abs_b_s  = b_neg_s ? -src_b : src_b;
`ifdef MIPS_MULDIV_DIV_EN
        op_ok_s  = 1'b1;
`else
        op_ok_s  = ~div_op_s;
`endif
        accept_s = (state_q == ST_IDLE) && start && !flush && op_ok_s;
    end

    // STEPS iterations chained combinationally each CALC cycle.
    for (genvar g = 0; g < STEPS; g++) begin : g_step
        logic [WIDTH-1:0] hi_in_s, lo_in_s, hi_out_s, lo_out_s;
        if (g == 0) begin : g_first
            assign hi_in_s = acc_hi_q;
            assign lo_in_s = acc_lo_q;
        end else begin : g_next
            assign hi_in_s = g_step[g-1].hi_out_s;
            assign lo_in_s = g_step[g-1].lo_out_s;
        end
        mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
            .is_div  (is_div_q),
            .hi_in   (hi_in_s),
            .lo_in   (lo_in_s),
            .operand (mcand_q),
            .hi_out  (hi_out_s),
            .lo_out  (lo_out_s)
        );
    end
    assign step_hi_s = g_step[STEPS-1].hi_out_s;
    assign step_lo_s = g_step[STEPS-1].lo_out_s;

    // Sign correction of the magnitude result produced in CALC.
    always_comb begin
        prod_s = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
`ifdef MIPS_MULDIV_DIV_EN
        if (is_div_q) begin
            // Divide by zero leaves |a| as remainder, so the sign fix
            // restores src_a in HI; only LO needs forcing.
            fix_lo_s = dbz_q ? {WIDTH{1'b1}} : (neg_q ? -acc_lo_q : acc_lo_q);
            fix_hi_s = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
`else
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
`endif
    end

    // Sequencer next-state, datapath loads and HI/LO write arbitration.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MIPS_MULDIV_DIV_EN
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        dbz_out_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = ST_CALC;
                    count_d  = CW'(N);
                    busy_d   = 1'b1;
                    is_div_d = div_op_s;
                    neg_d    = a_neg_s ^ b_neg_s;
                    acc_hi_d = {WIDTH{1'b0}};
                    if (div_op_s) begin
                        acc_lo_d = abs_a_s;
                        mcand_d  = abs_b_s;
                    end else begin
                        acc_lo_d = abs_b_s;
                        mcand_d  = abs_a_s;
                    end
`ifdef MIPS_MULDIV_DIV_EN
                    neg_rem_d = a_neg_s;
                    dbz_d     = div_op_s && (src_b == {WIDTH{1'b0}});
`endif
                end else begin
                    if (hi_we) hi_d = wdata; else hi_d = hi_q;
                    if (lo_we) lo_d = wdata; else lo_d = lo_q;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    count_d = {CW{1'b0}};
                    busy_d  = 1'b0;
                end else begin
                    acc_hi_d = step_hi_s;
                    acc_lo_d = step_lo_s;
                    count_d  = count_q - CW'(1'b1);
                    if (count_q == CW'(1'b1)) state_d = ST_FIX;
                    else                      state_d = ST_CALC;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (flush) begin
                    done_d = 1'b0;
                end else begin
                    hi_d   = fix_hi_s;
                    lo_d   = fix_lo_s;
                    done_d = 1'b1;
`ifdef MIPS_MULDIV_DIV_EN
                    dbz_out_d = dbz_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = {CW{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset outranks every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= {CW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_hi_q <= {WIDTH{1'b0}};
            acc_lo_q <= {WIDTH{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
`ifdef MIPS_MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            dbz_out_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MIPS_MULDIV_DIV_EN
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            dbz_out_q <= dbz_out_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MIPS_MULDIV_DIV_EN
    assign div_by_zero = dbz_out_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mips_muldiv.sv
// ---------------------------------------------------------------------------
// tb_mips_muldiv -- directed self-checking bench for mips_muldiv.
// A WIDTH=32/STEPS=1 instance carries most scenarios; a WIDTH=16/STEPS=4
// instance exercises the multi-step chain. Divide vectors are used when
// MIPS_MULDIV_DIV_EN is defined, otherwise divide starts must be ignored.
// ---------------------------------------------------------------------------
module tb_mips_muldiv;

    localparam int N32 = 32;
    localparam int N16 = 4;

    logic        clock = 1'b0;
    logic        reset, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        start16, flush16, hi_we16, lo_we16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, wdata16;
    logic        busy16, done16, dbz16;
    logic [15:0] hi16, lo16;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int cyc;
    int d0;

    always #5 clock = ~clock;

    // Count every done pulse of the 32-bit instance.
    always @(negedge clock) if (done) done_cnt++;

    mips_muldiv #(.WIDTH(32), .STEPS(1)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush), .hi_we(hi_we),
        .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    mips_muldiv #(.WIDTH(16), .STEPS(4)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .op(op16),
        .src_a(a16), .src_b(b16), .flush(flush16), .hi_we(hi_we16),
        .lo_we(lo_we16), .wdata(wdata16), .busy(busy16), .done(done16),
        .hi(hi16), .lo(lo16), .div_by_zero(dbz16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input string tag);
        int c;
        op = o; src_a = a; src_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        while (!done && c < 100) begin
            tick();
            c++;
        end
        check({tag, "_lat"}, 64'(c), 64'(N32 + 2));
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
        check({tag, "_idle"}, 64'(busy), 64'd0);
        tick();
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; src_a = 32'h0; src_b = 32'h0; wdata = 32'h0;
        start16 = 1'b0; flush16 = 1'b0; hi_we16 = 1'b0; lo_we16 = 1'b0;
        op16 = 2'b00; a16 = 16'h0; b16 = 16'h0; wdata16 = 16'h0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);

        // MTLO / MTHI while idle
        lo_we = 1'b1; wdata = 32'd5; tick(); lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'd5);
        hi_we = 1'b1; wdata = 32'h1234; tick(); hi_we = 1'b0;
        check("mthi", 64'(hi), 64'h1234);

        // Multiplies
        do_op(2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_m3x7");
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
        do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minsq");
        do_op(2'b01, 32'd12345, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7, 1'b0, "mult_neg1");
        do_op(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, "multu_2p32");

        // MTHI while busy is ignored
        op = 2'b00; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0; hi_we = 1'b1; wdata = 32'hDEAD;
        tick();
        hi_we = 1'b0;
        check("mthi_busy", 64'(hi), 64'd1);
        cyc = 2;
        while (!done && cyc < 100) begin tick(); cyc++; end
        check("mthi_busy_lat", 64'(cyc), 64'(N32 + 2));
        check("mthi_busy_lo", 64'(lo), 64'd6);

        // MTHI together with an accepted start is dropped
        tick();
        op = 2'b00; src_a = 32'd1; src_b = 32'd1; start = 1'b1; hi_we = 1'b1; wdata = 32'hAAAA;
        tick();
        start = 1'b0; hi_we = 1'b0;
        check("we_start_busy", 64'(busy), 64'd1);
        check("we_start_hi", 64'(hi), 64'd0);
        cyc = 1;
        while (!done && cyc < 100) begin tick(); cyc++; end
        check("we_start_lo", 64'(lo), 64'd1);
        tick();

        // start at t, second start at t+5, flush at t+10
        d0 = done_cnt;
        op = 2'b00; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        src_a = 32'd9; src_b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'd0);
        check("flush_lo", 64'(lo), 64'd1);
        repeat (40) tick();
        check("flush_no_done", 64'(done_cnt), 64'(d0));
        check("flush_no_second", 64'(lo), 64'd1);

        // flush idle has no effect; flush with start drops the start
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);
        check("flush_idle_lo", 64'(lo), 64'd1);
        d0 = done_cnt;
        op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        repeat (40) tick();
        check("flush_start_done", 64'(done_cnt), 64'(d0));

        // reset at t+3 of a MULT
        hi_we = 1'b1; wdata = 32'h55; tick(); hi_we = 1'b0;
        check("mthi_55", 64'(hi), 64'h55);
        d0 = done_cnt;
        op = 2'b01; src_a = 32'hFFFFFFFD; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmid_busy", 64'(busy), 64'd0);
        check("rmid_done", 64'(done), 64'd0);
        check("rmid_hi", 64'(hi), 64'd0);
        check("rmid_lo", 64'(lo), 64'd0);
        check("rmid_dbz", 64'(div_by_zero), 64'd0);
        repeat (40) tick();
        check("rmid_no_done", 64'(done_cnt), 64'(d0));

`ifdef MIPS_MULDIV_DIV_EN
        do_op(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7by2");
        do_op(2'b11, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7bym2");
        do_op(2'b10, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 1'b1, "divu_by0");
        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_minbym1");
        do_op(2'b10, 32'hFFFFFFFF, 32'd1, 32'h00000000, 32'hFFFFFFFF, 1'b0, "divu_maxby1");
        do_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100by7");
`else
        d0 = done_cnt;
        op = 2'b10; src_a = 32'd7; src_b = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("divu_off_busy", 64'(busy), 64'd0);
        repeat (40) tick();
        check("divu_off_done", 64'(done_cnt), 64'(d0));
        check("divu_off_lo", 64'(lo), 64'd0);
`endif

        // WIDTH=16, STEPS=4 instance
        op16 = 2'b00; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        cyc = 1;
        while (!done16 && cyc < 50) begin tick(); cyc++; end
        check("w16_lat", 64'(cyc), 64'(N16 + 2));
        check("w16_hi", 64'(hi16), 64'hFFFE);
        check("w16_lo", 64'(lo16), 64'h0001);
        tick();
        op16 = 2'b01; a16 = 16'h8000; b16 = 16'd2; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        cyc = 1;
        while (!done16 && cyc < 50) begin tick(); cyc++; end
        check("w16_mult_lat", 64'(cyc), 64'(N16 + 2));
        check("w16_mult_hi", 64'(hi16), 64'hFFFF);
        check("w16_mult_lo", 64'(lo16), 64'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
